// File: rtl/delay_line_mc_pkg.sv
// delay_line_mc_pkg: shared synth constants, FSM state type and saturation helper
package delay_line_mc_pkg;
  localparam int FB_W = 8;
  localparam int FB_FRAC = 7;
  typedef enum logic [1:0] {IDLE, RD, MIX, WR} state_t;
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return v > hi ? hi : (v < lo ? lo : v);
  endfunction
endpackage

// File: rtl/delay_line_ram.sv
// delay_line_ram: single-port RAM, registered write-first read, zero-initialised
module delay_line_ram #(
  parameter int DATA_W = 17,
  parameter int ADDR_W = 12,
  parameter int DEPTH = 4096
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] di,
  output logic [DATA_W-1:0] dout
);
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
  // write-first port: a write also returns the written word
  always_ff @(posedge clk)
    if (en) begin
      if (we) mem[addr] <= di;
      dout <= we ? di : mem[addr];
    end
endmodule

// File: rtl/delay_line_mc.sv
// delay_line_mc: multi-channel circular delay line with variable tap and feedback
module delay_line_mc
  import delay_line_mc_pkg::*;
#(
  parameter int DATA_W = 17,
  parameter int ADDR_W = 10,
  parameter int CHANNELS = 4,
  localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH_W-1:0]          in_ch,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0]        in_delay,
  input  logic signed [FB_W-1:0]   in_fb,
  output logic                     out_valid,
  output logic [CH_W-1:0]          out_ch,
  output logic signed [DATA_W-1:0] out_data
);
  state_t state;
  logic [CH_W-1:0] ch_q;
  logic signed [DATA_W-1:0] data_q, tap_q, wv_q, ram_q, tap;
  logic [ADDR_W-1:0] delay_q, ptr;
  logic signed [FB_W-1:0] fb_q;
  logic [ADDR_W-1:0] wptr [CHANNELS];
  logic signed [DATA_W+FB_W-1:0] prod;
  logic signed [DATA_W:0] sum;
  logic signed [63:0] sat_v;
  logic ram_en, ram_we;
  logic [CH_W+ADDR_W-1:0] ram_addr;

  assign ptr = wptr[ch_q];
  assign ram_en = state == RD || state == WR;
  assign ram_we = state == WR;
  assign ram_addr = {ch_q, state == WR ? ptr : ptr - delay_q};

  delay_line_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(CH_W + ADDR_W),
    .DEPTH (CHANNELS << ADDR_W)
  ) u_ram (
    .clk (clk),
    .en  (ram_en),
    .we  (ram_we),
    .addr(ram_addr),
    .di  (wv_q),
    .dout(ram_q)
  );

  // tap selection (zero delay bypasses the RAM) and saturating feedback mix
  always_comb begin
    tap = delay_q == '0 ? data_q : ram_q;
    prod = tap * fb_q;
    sum = (DATA_W + 1)'(data_q) + (DATA_W + 1)'(prod >>> FB_FRAC);
    sat_v = sat(64'(sum), DATA_W);
  end

  // read-mix-write sequencer with registered handshake and output
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      out_ch <= '0;
      out_data <= '0;
      ch_q <= '0;
      data_q <= '0;
      delay_q <= '0;
      fb_q <= '0;
      tap_q <= '0;
      wv_q <= '0;
      wptr <= '{default: '0};
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE:
          if (in_valid) begin
            ch_q <= in_ch;
            data_q <= in_data;
            delay_q <= in_delay;
            fb_q <= in_fb;
            if (32'(in_ch) < CHANNELS) begin
              state <= RD;
              in_ready <= 1'b0;
            end
          end
        RD: state <= MIX;
        MIX: begin
          tap_q <= tap;
          wv_q <= sat_v[DATA_W-1:0];
          state <= WR;
        end
        WR: begin
          out_data <= tap_q;
          out_ch <= ch_q;
          out_valid <= 1'b1;
          wptr[ch_q] <= ptr + 1'b1;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_delay_line_mc.sv
// tb_delay_line_mc: directed and random checks against a circular-buffer reference model
module tb_delay_line_mc;
  localparam int DATA_W = 17, ADDR_W = 10, CHANNELS = 4, CH_W = 2, DEPTH = 1 << ADDR_W;
  logic clk = 0, rst_n = 0, in_valid = 0, in_ready, out_valid;
  logic [CH_W-1:0] in_ch = 0, out_ch;
  logic signed [DATA_W-1:0] in_data = 0, out_data;
  logic [ADDR_W-1:0] in_delay = 0;
  logic signed [7:0] in_fb = 0;
  int errors = 0, checks = 0, last_tap;
  int mem [CHANNELS][DEPTH];
  int wp [CHANNELS];

  always #5 clk = ~clk;

  delay_line_mc #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CHANNELS(CHANNELS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ch(in_ch), .in_data(in_data), .in_delay(in_delay), .in_fb(in_fb),
    .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int model(input int ch, input int data, input int dly, input int fb);
    int tap, wv;
    tap = dly == 0 ? data : mem[ch][(wp[ch] - dly + DEPTH) % DEPTH];
    wv = data + ((tap * fb) >>> 7);
    wv = wv > 65535 ? 65535 : (wv < -65536 ? -65536 : wv);
    mem[ch][wp[ch]] = wv;
    wp[ch] = (wp[ch] + 1) % DEPTH;
    return tap;
  endfunction

  task automatic send(input int ch, input int data, input int dly, input int fb);
    int exp;
    @(negedge clk);
    chk("ready_before", int'(in_ready), 1);
    in_valid = 1;
    in_ch = CH_W'(ch);
    in_data = DATA_W'(data);
    in_delay = ADDR_W'(dly);
    in_fb = 8'(fb);
    exp = model(ch, data, dly, fb);
    @(posedge clk);
    #1 in_valid = 0;
    for (int k = 0; k < 3; k++) begin
      chk("busy_ready", int'(in_ready), 0);
      chk("busy_valid", int'(out_valid), 0);
      @(posedge clk);
      #1;
    end
    chk("out_valid", int'(out_valid), 1);
    chk("out_ch", int'(out_ch), ch);
    chk("out_data", int'(out_data), exp);
    chk("ready_after", int'(in_ready), 1);
    last_tap = int'(out_data);
    @(posedge clk);
    #1 chk("pulse_end", int'(out_valid), 0);
  endtask

  initial begin
    int t2 [5] = '{0, 0, 0, 1, 2};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_ch", int'(out_ch), 0);
    @(negedge clk) rst_n = 1;
    // reset in the middle of a sequence
    send(0, 555, 0, 0);
    chk("bypass_555", last_tap, 555);
    @(negedge clk);
    in_valid = 1; in_ch = 0; in_data = 777; in_delay = 0; in_fb = 0;
    @(posedge clk);
    #1 in_valid = 0;
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("midrst_ready", int'(in_ready), 1);
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_data", int'(out_data), 0);
    for (int i = 0; i < CHANNELS; i++) wp[i] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    send(0, 5, 1, 0);
    chk("post_rst_tap", last_tap, 0);
    // fixed delay of three on a fresh channel
    for (int i = 0; i < 5; i++) begin
      send(3, i + 1, 3, 0);
      chk("d3_seq", last_tap, t2[i]);
    end
    // bypass then feedback
    send(0, 100, 0, 64);
    chk("bypass", last_tap, 100);
    send(0, 7, 1, 0);
    chk("fb_half", last_tap, 150);
    // positive saturation on ch1, negative on ch2
    send(1, 60000, 1, 127);
    chk("satp0", last_tap, 0);
    send(1, 60000, 1, 127);
    chk("satp1", last_tap, 60000);
    send(1, 60000, 1, 127);
    chk("satp2", last_tap, 65535);
    send(2, -60000, 1, 127);
    chk("satn0", last_tap, 0);
    send(2, -60000, 1, 127);
    chk("satn1", last_tap, -60000);
    send(2, -60000, 1, 127);
    chk("satn2", last_tap, -65536);
    // interleaved channels stay isolated
    for (int i = 0; i < 3; i++) begin
      send(0, 10 + i, 1, 0);
      if (i > 0) chk("iso_ch0", last_tap, 9 + i);
      send(1, 20 + i, 1, 0);
      if (i > 0) chk("iso_ch1", last_tap, 19 + i);
    end
    // pointer wrap with maximum delay
    for (int i = 0; i < 1030; i++) begin
      send(2, i, 1023, 0);
      if (i == 1023) chk("wrap_1023", last_tap, 0);
      if (i == 1029) chk("wrap_1029", last_tap, 6);
    end
    send(0, 13, 1, 0);
    chk("ch0_after_wrap", last_tap, 12);
    // random traffic
    for (int i = 0; i < 60; i++)
      send(int'($urandom_range(0, 3)), int'($urandom_range(0, 131071)) - 65536,
           int'($urandom_range(0, 8)), int'($urandom_range(0, 255)) - 128);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
